bus32_epc_master: RTL
=====================

Name: bus32_epc_master

Overview:
- Initiator for the 32-bit EPC-style register bus used by the bus32 register cells.
- Takes single read/write commands from an internal command port and drives the bus strobes, address, data and byte enables.
- Waits for the responder's ready, captures read data, and returns one response per command.
- Bounded by a programmable timeout so a silent address never hangs the initiator.

Parameters:
- datawidth, 32, bus data width in bits (multiple of 8).
- addrwidth, 8, bus address width in bits.
- timeout_cycles, 255, maximum ACCESS cycles before abort; 0 disables timeout.

Ports:
- clock_in  input  1  single system clock, all logic on rising edge.
- reset_in  input  1  synchronous, active-high reset.
- cmd_valid_in  input  1  command request.
- cmd_ready_out  output  1  high when a command can be accepted (state IDLE).
- cmd_write_in  input  1  1 = write, 0 = read.
- cmd_addr_in  input  addrwidth  target address.
- cmd_data_in  input  datawidth  write data (ignored for reads).
- cmd_be_in  input  datawidth/8  byte enables.
- rsp_valid_out  output  1  one-cycle response pulse.
- rsp_data_out  output  datawidth  read data; 0 for writes; all-ones on timeout.
- rsp_timeout_out  output  1  qualifies rsp_valid_out: access aborted by timeout.
- busy_out  output  1  high in any state other than IDLE.
- epc_addr_out  output  addrwidth  bus address.
- epc_data_out  output  datawidth  bus write data.
- epc_data_in  input  datawidth  bus read data from responder.
- epc_be_out  output  datawidth/8  bus byte enables.
- epc_cs_n_out  output  1  chip select, active low.
- epc_wr_n_out  output  1  write strobe, active low.
- epc_rd_n_out  output  1  read strobe, active low.
- epc_rdy_in  input  1  responder ready/acknowledge, active high.

Behaviour:
- All bus outputs are registered. Reset values:
  - epc_cs_n/wr_n/rd_n = 1.
  - addr, data, be = 0.
  - rsp_valid, rsp_timeout, rsp_data = 0.
  - busy_out = 0; cmd_ready_out = 1 (state IDLE).
- FSM states: IDLE, SETUP, ACCESS, RECOVER, RESP.
- IDLE:
  - cmd_ready_out = 1.
  - On cmd_valid_in at a clock edge, latch write/addr/data/be into the bus output registers and go to SETUP.
- SETUP (1 cycle):
  - cs_n = 0, addr/be/data stable, wr_n = rd_n = 1.
  - Go to ACCESS; the timeout counter clears to 0.
- ACCESS:
  - cs_n = 0; wr_n = 0 for writes, rd_n = 0 for reads; never both low.
  - Counter increments each cycle while epc_rdy_in is low.
  - epc_rdy_in sampled high → RECOVER, timeout flag 0.
  - Else if timeout_cycles != 0 and counter == timeout_cycles-1 → RECOVER, timeout flag 1.
  - If rdy and the timeout condition occur in the same cycle, rdy wins (no timeout).
- RECOVER (1 cycle):
  - cs_n, wr_n, rd_n all 1; addr/data/be held.
  - For a successful read, capture epc_data_in at the end of this cycle; the responder registers its data on the rdy cycle.
  - Go to RESP.
- RESP (1 cycle):
  - rsp_valid_out = 1.
  - rsp_data_out = captured data for a read, 0 for a write, all-ones on timeout.
  - rsp_timeout_out = timeout flag.
  - cmd_ready_out = 0. Next state IDLE; rsp_valid and rsp_timeout return to 0.
- Minimum transaction, accept edge to rsp_valid, with rdy on the first ACCESS cycle: SETUP(1) + ACCESS(1) + RECOVER(1) + RESP(1).
- Back-to-back commands: the next command is accepted in the first IDLE cycle. Bus strobes are therefore high for at least 2 cycles (RECOVER, RESP) between accesses.
- epc_rdy_in is ignored outside ACCESS.
- cmd_* inputs are ignored outside IDLE; no queuing.
- Counter width is ceil(log2(timeout_cycles+1)), minimum 1. It saturates and never wraps.
- Reset mid-transaction: at the next edge all strobes go high, FSM returns to IDLE, and no response is issued for the aborted command.

Test Plan:
- Read, responder model asserts rdy on the 2nd ACCESS cycle and returns 32'h54460001 at addr 8'h00 → one rsp_valid pulse, rsp_data = 32'h54460001, rsp_timeout = 0, rd_n low exactly 2 cycles, wr_n stays 1.
- Write 32'hA5A5_0003 to 8'h04, be = 4'b0101, rdy on 1st ACCESS cycle → bus shows addr 8'h04, data/be stable from SETUP through RECOVER, wr_n low 1 cycle; rsp_data = 0, timeout = 0.
- Read to an address with no rdy, timeout_cycles = 8 → rd_n low exactly 8 cycles, then rsp_valid with rsp_timeout = 1 and rsp_data = 32'hFFFFFFFF.
- Rdy asserted on exactly the last allowed ACCESS cycle (cycle 8, timeout_cycles = 8) → normal completion, rsp_timeout = 0.
- Two commands held valid continuously → second accepted the cycle after the first rsp_valid pulse; cs_n high ≥ 2 cycles between accesses; two rsp pulses in order.
- reset_in asserted for 1 cycle during ACCESS of a read → strobes high next cycle, FSM IDLE, no rsp_valid; a following read completes normally.

Source files
------------

// File: rtl/bus32_epc_master.sv
// Single-outstanding initiator for the 32-bit EPC register bus: one response per command, at least 4 cycles after accept.
// Backpressure: cmd_ready_out is high only in IDLE; a silent responder is cut off by the ACCESS timeout.
module bus32_epc_master #(
  parameter int datawidth      = 32,
  parameter int addrwidth      = 8,
  parameter int timeout_cycles = 255
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic                     cmd_valid_in,
  output logic                     cmd_ready_out,
  input  logic                     cmd_write_in,
  input  logic [addrwidth-1:0]     cmd_addr_in,
  input  logic [datawidth-1:0]     cmd_data_in,
  input  logic [datawidth/8-1:0]   cmd_be_in,
  output logic                     rsp_valid_out,
  output logic [datawidth-1:0]     rsp_data_out,
  output logic                     rsp_timeout_out,
  output logic                     busy_out,
  output logic [addrwidth-1:0]     epc_addr_out,
  output logic [datawidth-1:0]     epc_data_out,
  input  logic [datawidth-1:0]     epc_data_in,
  output logic [datawidth/8-1:0]   epc_be_out,
  output logic                     epc_cs_n_out,
  output logic                     epc_wr_n_out,
  output logic                     epc_rd_n_out,
  input  logic                     epc_rdy_in
);

  localparam int BEW = datawidth / 8;
  localparam int CW  = (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  localparam logic [CW-1:0] TLAST = CW'((timeout_cycles > 0) ? timeout_cycles - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RECOVER,
    ST_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_write;
  logic                r_timeout;
  logic [CW-1:0]       r_cnt;
  logic                r_cs_n;
  logic                r_wr_n;
  logic                r_rd_n;
  logic [addrwidth-1:0] r_addr;
  logic [datawidth-1:0] r_data;
  logic [BEW-1:0]      r_be;
  logic                r_rsp_valid;
  logic                r_rsp_timeout;
  logic [datawidth-1:0] r_rsp_data;
  logic                w_accept;
  logic                w_expire;

  assign w_accept = (r_state == ST_IDLE) && cmd_valid_in;
  assign w_expire = (timeout_cycles != 0) && (r_cnt == TLAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (cmd_valid_in) w_next = ST_SETUP;
      ST_SETUP:   w_next = ST_ACCESS;
      ST_ACCESS:  if (epc_rdy_in || w_expire) w_next = ST_RECOVER;
      ST_RECOVER: w_next = ST_RESP;
      ST_RESP:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Strobes are decoded from the next state so they are registered yet line up with the FSM.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_write       <= 1'b0;
      r_timeout     <= 1'b0;
      r_cnt         <= '0;
      r_cs_n        <= 1'b1;
      r_wr_n        <= 1'b1;
      r_rd_n        <= 1'b1;
      r_addr        <= '0;
      r_data        <= '0;
      r_be          <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_data    <= '0;
    end else begin
      r_cs_n        <= !((w_next == ST_SETUP) || (w_next == ST_ACCESS));
      r_wr_n        <= !((w_next == ST_ACCESS) && r_write);
      r_rd_n        <= !((w_next == ST_ACCESS) && !r_write);
      r_rsp_valid   <= (r_state == ST_RECOVER);
      r_rsp_timeout <= (r_state == ST_RECOVER) && r_timeout;

      if (w_accept) begin
        r_write <= cmd_write_in;
        r_addr  <= cmd_addr_in;
        r_data  <= cmd_data_in;
        r_be    <= cmd_be_in;
      end

      case (r_state)
        ST_SETUP: begin
          r_cnt     <= '0;
          r_timeout <= 1'b0;
        end
        ST_ACCESS: begin
          if (!epc_rdy_in && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
          // rdy in the same cycle as expiry counts as a normal completion
          r_timeout <= !epc_rdy_in && w_expire;
        end
        ST_RECOVER: begin
          if (r_timeout)    r_rsp_data <= '1;
          else if (r_write) r_rsp_data <= '0;
          else              r_rsp_data <= epc_data_in;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready_out   = (r_state == ST_IDLE);
  assign busy_out        = (r_state != ST_IDLE);
  assign rsp_valid_out   = r_rsp_valid;
  assign rsp_timeout_out = r_rsp_timeout;
  assign rsp_data_out    = r_rsp_data;
  assign epc_addr_out    = r_addr;
  assign epc_data_out    = r_data;
  assign epc_be_out      = r_be;
  assign epc_cs_n_out    = r_cs_n;
  assign epc_wr_n_out    = r_wr_n;
  assign epc_rd_n_out    = r_rd_n;

endmodule
